fifo_port_sched: RTL and testbench
==================================

# fifo_port_sched

Scheduler that shares the single-port-per-cycle 8-bit FIFO between NUM_REQ write requesters and one read consumer. The FIFO cannot accept a write and a read in the same cycle, so this block serialises the two.
- Writers are granted in round-robin bursts of up to MAX_BURST words.
- Reads and writes alternate fairly when they collide.
- FIFO Full/Empty flags are respected, so the FIFO never sees an overflow or underflow.

## Interface
- NUM_REQ, 4, number of write requesters (2..8)
- DATA_W, 8, word width; matches FIFO data width
- MAX_BURST, 4, max words accepted per grant before re-arbitration (1..15)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  requester i has a word pending; held with data until ack[i]
- req_data  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- ack  out  NUM_REQ  one-hot pulse; word of requester i written this cycle
- rd_req  in  1  consumer wants one word
- rd_valid  out  1  FIFO read data valid this cycle (one cycle after fifo_read)
- fifo_wr_data  out  DATA_W  to FIFO write data
- fifo_write  out  1  to FIFO write strobe
- fifo_read  out  1  to FIFO read strobe
- fifo_full  in  1  FIFO Full flag
- fifo_empty  in  1  FIFO Empty flag
- grant_id  out  clog2(NUM_REQ)  currently/last granted requester
- busy  out  1  state is BURST
- stall_count  out  16  write-stall cycle counter (see Configuration)

## Operation
- States: IDLE, BURST. Registers: state, rr_ptr, grant_id, burst_cnt (4 bits), wr_blocked_q, rd_valid.
- IDLE: if any req, pick the first set bit scanning from rr_ptr upward, wrapping mod NUM_REQ. Load grant_id, clear burst_cnt, go to BURST. No word is accepted in IDLE.
- The read/write arbitration below is evaluated in every state.
- fifo_read = rd_req & !fifo_empty & !(wr_blocked_q).
- acc = (state==BURST) & req[grant_id] & !fifo_full & !fifo_read.
- fifo_write = acc. fifo_wr_data = req_data slice of grant_id. ack = acc ? onehot(grant_id) : 0. All combinational.
- wr_blocked_q next = (state==BURST) & req[grant_id] & !fifo_full & fifo_read.
  - After one collision lost by the writer, the next cycle the write wins and the read waits.
- On acc, burst_cnt increments.
- BURST exits to IDLE when any of the following holds:
  - acc & burst_cnt==MAX_BURST-1
  - !req[grant_id]
  - fifo_full
- On exit, rr_ptr = (grant_id+1) mod NUM_REQ.
- rd_valid next = fifo_read.
- Boundaries:
  - fifo_full: write never asserted.
  - fifo_empty: read never asserted; rd_req simply waits.
  - Single requester: re-granted after one IDLE cycle.
  - rr_ptr wrap-around from NUM_REQ-1 to 0.
- Reset mid-burst: state IDLE immediately, pending word not acked; requester keeps req and is re-arbitrated.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_id 0, burst_cnt 0, wr_blocked_q 0, rd_valid 0, stall_count 0.
  - Therefore ack 0, fifo_write 0, busy 0, and fifo_read 0 while reset is asserted.
- Arbitration latency: req rising in IDLE to first ack is 2 cycles (grant edge, then accept).
- Sustained throughput: MAX_BURST words per MAX_BURST+1 cycles per grant, absent reads.
- Collision: with rd_req and req both continuously active, read and write alternate cycle by cycle.
- rd_valid is exactly 1 cycle after fifo_read, aligned with FIFO re_data.

## Configuration
- FIFO_PORT_SCHED_STATS_EN defined:
  - stall_count increments (saturating at 0xFFFF) every cycle with state==BURST & req[grant_id] & !acc.
  - Cleared by reset.
- Not defined: stall_count tied to 0, no counter register.

## Structure
- Shared package fifo_port_sched_pkg holds:
  - state encoding enum (IDLE, BURST)
  - burst counter width constant
  - stall counter width constant (16)
- Sub-module rr_pick (NUM_REQ param): inputs req vector and rr_ptr; outputs found and index. Pure combinational rotate-and-priority-encode.

## Test plan
- Reset then req=4'b0001, data 0xA5, fifo not full: ack[0] and fifo_write with 0xA5 on cycle 2 after req; busy high in between.
- req=4'b1111 held, MAX_BURST=4: grants 0,1,2,3,0 in order, 4 acks each, one IDLE gap between bursts.
- fifo_full asserted after 2 words of a burst: no further fifo_write; BURST exits to IDLE; resumes when fifo_full drops.
- rd_req=1, fifo_empty=0, req[2]=1 continuous: fifo_read and fifo_write alternate; rd_valid follows each fifo_read by 1 cycle.
- rd_req=1 with fifo_empty=1: fifo_read stays 0; reset asserted mid-burst: no ack that cycle, state IDLE, rr_ptr 0.
- Stats build: req[1] held with fifo_full=1 for 10 cycles in BURST -> stall_count=10. Non-stats build -> stall_count=0.

Source files
------------

// File: rtl/fifo_port_sched_pkg.sv
// Shared types and widths for the FIFO port scheduler.
package fifo_port_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int unsigned BURST_CNT_W = 4;
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_port_sched_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping mod NUM_REQ.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    always_comb begin
        logic [ID_W:0] pos;
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[ID_W-1:0]]) begin
                found = 1'b1;
                index = pos[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_port_sched.sv
// Serialises NUM_REQ round-robin write bursts and a read consumer onto a one-port FIFO.
// Optional write-stall statistics counter enabled by FIFO_PORT_SCHED_STATS_EN.
module fifo_port_sched
    import fifo_port_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = 4,
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      rd_req,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      fifo_write,
    output logic                      fifo_read,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [STALL_CNT_W-1:0]    stall_count
);

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        next_ptr;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   wr_blocked_q;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic                   grant_req;
    logic                   wr_pending;
    logic                   acc;
    logic                   burst_exit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign grant_req  = req[grant_id];
    assign wr_pending = (state == BURST) && grant_req && !fifo_full;
    assign burst_exit = (acc && (burst_cnt == BURST_CNT_W'(MAX_BURST - 1)))
                      || !grant_req || fifo_full;
    assign next_ptr   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign busy       = (state == BURST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = BURST;
            BURST:   if (burst_exit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port arbitration: a writer that lost a collision wins the following cycle
    always_comb begin
        fifo_read    = 1'b0;
        acc          = 1'b0;
        ack          = '0;
        fifo_wr_data = req_data[32'(grant_id)*DATA_W +: DATA_W];
        if (!reset) begin
            fifo_read = rd_req && !fifo_empty && !wr_blocked_q;
            acc       = wr_pending && !fifo_read;
        end
        fifo_write = acc;
        if (acc) begin
            ack[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            burst_cnt    <= '0;
            wr_blocked_q <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            wr_blocked_q <= wr_pending && fifo_read;
            rd_valid     <= fifo_read;
            if ((state == IDLE) && pick_found) begin
                grant_id  <= pick_idx;
                burst_cnt <= '0;
            end else if (acc) begin
                burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            end
            if ((state == BURST) && burst_exit) begin
                rr_ptr <= next_ptr;
            end
        end
    end

`ifdef FIFO_PORT_SCHED_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Cycles a granted writer had a word but could not write; saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == BURST) && grant_req && !acc && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fifo_port_sched.sv
// Randomised and directed bench for fifo_port_sched against a behavioural scheduler model.
module tb_fifo_port_sched;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        rd_req;
    logic        rd_valid;
    logic [7:0]  fifo_wr_data;
    logic        fifo_write;
    logic        fifo_read;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: burst owner, words taken, next search start, owed write turn
    bit   m_busy, m_owed, m_rdv;
    int   m_gid, m_words, m_ptr, m_stall;
    bit   e_rd, e_wr;
    logic [3:0] e_ack;
    logic [7:0] e_data;

    always #5 clk = ~clk;

    fifo_port_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .fifo_wr_data (fifo_wr_data),
        .fifo_write   (fifo_write),
        .fifo_read    (fifo_read),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .grant_id     (grant_id),
        .busy         (busy),
        .stall_count  (stall_count)
    );

    task automatic drive(input logic rst, input logic [3:0] rq, input logic rr,
                         input logic full, input logic empty, input logic [31:0] data);
        reset      = rst;
        req        = rq;
        rd_req     = rr;
        fifo_full  = full;
        fifo_empty = empty;
        req_data   = data;
        #2;
        e_rd   = !rst && rr && !empty && !m_owed;
        e_wr   = !rst && m_busy && rq[m_gid] && !full && !e_rd;
        e_ack  = e_wr ? 4'(1 << m_gid) : 4'b0;
        e_data = data[m_gid*8 +: 8];
    endtask

    task automatic tick();
        bit wants;
        bit found;
        int idx;
        wants = m_busy && req[m_gid] && !fifo_full;
        if (reset) begin
            m_busy = 0; m_owed = 0; m_rdv = 0;
            m_gid = 0; m_words = 0; m_ptr = 0; m_stall = 0;
        end else begin
`ifdef FIFO_PORT_SCHED_STATS_EN
            if (m_busy && req[m_gid] && !e_wr && m_stall < 65535) m_stall++;
`endif
            m_owed = wants && e_rd;
            m_rdv  = e_rd;
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (!found && req[idx]) begin
                        found = 1; m_busy = 1; m_gid = idx; m_words = 0;
                    end
                end
            end else begin
                if (e_wr) m_words++;
                if ((e_wr && m_words == MAX_BURST) || !req[m_gid] || fifo_full) begin
                    m_busy = 0;
                    m_ptr  = (m_gid + 1) % NUM_REQ;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 4'hF, 1, 0, 0, $urandom);
        n_tests++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_tests++; if (fifo_write !== 0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", fifo_write); end
        n_tests++; if (fifo_read !== 0)  begin n_fail++; $display("FAIL reset_read got=%b exp=0", fifo_read); end
        tick();
        drive(1, 4'hF, 1, 0, 0, $urandom);
        n_tests++; if (busy !== 0)         begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        n_tests++; if (rd_valid !== 0)     begin n_fail++; $display("FAIL reset_rdv got=%b exp=0", rd_valid); end
        n_tests++; if (stall_count !== 0)  begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
        tick();
    endtask

    task automatic test_single();
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        drive(0, 4'b0001, 0, 0, 0, 32'h000000A5);
        n_tests++; if (ack !== 4'b0 || busy !== 0) begin n_fail++; $display("FAIL single_c0 ack=%b busy=%b exp 0000/0", ack, busy); end
        tick();
        drive(0, 4'b0001, 0, 0, 0, 32'h000000A5);
        n_tests++; if (ack !== 4'b0001 || fifo_write !== 1) begin n_fail++; $display("FAIL single_ack ack=%b wr=%b exp 0001/1", ack, fifo_write); end
        n_tests++; if (fifo_wr_data !== 8'hA5 || busy !== 1) begin n_fail++; $display("FAIL single_data data=%h busy=%b exp a5/1", fifo_wr_data, busy); end
        tick();
        drive(0, 4'b0000, 0, 0, 0, 0);
        n_tests++; if (ack !== 4'b0) begin n_fail++; $display("FAIL single_drop ack=%b exp 0000", ack); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        logic [7:0] exp_dat;
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 25; c++) begin
            exp_ack = (c % 5 == 0) ? 4'b0 : 4'(1 << ((c / 5) % 4));
            exp_dat = 8'(8'h11 * (((c / 5) % 4) + 1));
            drive(0, 4'hF, 0, 0, 0, 32'h44332211);
            n_tests++;
            if (ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", c, ack, exp_ack); end
            if (exp_ack != 0) begin
                n_tests++;
                if (fifo_wr_data !== exp_dat) begin n_fail++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, fifo_wr_data, exp_dat); end
            end
            tick();
        end
    endtask

    task automatic test_full();
        bit resumed;
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        resumed = 0;
        for (int c = 0; c < 14; c++) begin
            drive(0, 4'b0100, 0, (c >= 3 && c <= 10), 0, 32'h00C30000);
            n_tests++;
            if (fifo_write !== e_wr) begin n_fail++; $display("FAIL full_wr cyc=%0d got=%b exp=%b", c, fifo_write, e_wr); end
            if (c >= 3 && c <= 10) begin
                n_tests++;
                if (fifo_write !== 0) begin n_fail++; $display("FAIL full_blocked cyc=%0d got=%b exp=0", c, fifo_write); end
            end
            if (c == 4) begin
                n_tests++;
                if (busy !== 0) begin n_fail++; $display("FAIL full_exit busy=%b exp=0", busy); end
            end
            if (c >= 11 && fifo_write === 1 && fifo_wr_data === 8'hC3) resumed = 1;
            tick();
        end
        n_tests++;
        if (!resumed) begin n_fail++; $display("FAIL full_resume got=no_write exp=write"); end
    endtask

    task automatic test_collision();
        bit exp_rd, exp_wr, prev_rd;
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        prev_rd = 0;
        for (int c = 0; c < 9; c++) begin
            exp_rd = (c == 0) || (c % 2 == 1);
            exp_wr = (c >= 2) && (c % 2 == 0);
            drive(0, 4'b0100, 1, 0, 0, 32'h005A0000);
            n_tests++;
            if (fifo_read !== exp_rd || fifo_write !== exp_wr) begin
                n_fail++; $display("FAIL coll_alt cyc=%0d rd=%b wr=%b exp %b/%b", c, fifo_read, fifo_write, exp_rd, exp_wr);
            end
            if (c >= 1) begin
                n_tests++;
                if (rd_valid !== prev_rd) begin n_fail++; $display("FAIL coll_rdv cyc=%0d got=%b exp=%b", c, rd_valid, prev_rd); end
            end
            prev_rd = exp_rd;
            tick();
        end
    endtask

    task automatic test_empty_reset();
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 7; c++) begin
            drive(0, 4'hF, 1, 0, 1, 32'h44332211);
            n_tests++;
            if (fifo_read !== 0) begin n_fail++; $display("FAIL empty_rd cyc=%0d got=%b exp=0", c, fifo_read); end
            tick();
        end
        drive(1, 4'hF, 1, 0, 1, 32'h44332211);
        n_tests++;
        if (ack !== 4'b0 || fifo_write !== 0) begin n_fail++; $display("FAIL midrst_ack ack=%b wr=%b exp 0000/0", ack, fifo_write); end
        tick();
        drive(0, 4'hF, 1, 0, 1, 32'h44332211);
        n_tests++;
        if (busy !== 0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_idle busy=%b gid=%0d exp 0/0", busy, grant_id); end
        tick();
        drive(0, 4'hF, 1, 0, 1, 32'h44332211);
        n_tests++;
        if (ack !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_regrant ack=%b gid=%0d exp 0001/0", ack, grant_id); end
        tick();
    endtask

    task automatic test_stats();
        int exp_stall;
`ifdef FIFO_PORT_SCHED_STATS_EN
        exp_stall = 10;
`else
        exp_stall = 0;
`endif
        drive(1, 4'h0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 20; c++) begin
            drive(0, 4'b0010, 0, 1, 0, 32'h0000EE00);
            tick();
        end
        drive(0, 4'b0010, 0, 1, 0, 32'h0000EE00);
        n_tests++;
        if (stall_count !== 16'(exp_stall)) begin n_fail++; $display("FAIL stats_count got=%0d exp=%0d", stall_count, exp_stall); end
        n_tests++;
        if (stall_count !== 16'(m_stall)) begin n_fail++; $display("FAIL stats_model got=%0d exp=%0d", stall_count, m_stall); end
        tick();
    endtask

    task automatic test_random();
        bit         pend[4];
        logic [7:0] dat[4];
        logic [3:0] rq;
        logic [31:0] pd;
        bit         rst;
        int         gid_now;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; dat[i] = 0; end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) begin pend[i] = 1; dat[i] = 8'($urandom); end
            end
            rq = {pend[3], pend[2], pend[1], pend[0]};
            pd = {dat[3], dat[2], dat[1], dat[0]};
            rst = ($urandom_range(79) == 0);
            drive(rst, rq, $urandom_range(1) == 1, $urandom_range(4) == 0, $urandom_range(3) == 0, pd);
            n_tests++;
            if (ack !== e_ack || fifo_write !== e_wr || fifo_read !== e_rd) begin
                n_fail++; $display("FAIL rand_ports cyc=%0d ack=%b wr=%b rd=%b exp %b/%b/%b", c, ack, fifo_write, fifo_read, e_ack, e_wr, e_rd);
            end
            n_tests++;
            if (busy !== m_busy || rd_valid !== m_rdv || stall_count !== 16'(m_stall)) begin
                n_fail++; $display("FAIL rand_regs cyc=%0d busy=%b rdv=%b stall=%0d exp %b/%b/%0d", c, busy, rd_valid, stall_count, m_busy, m_rdv, m_stall);
            end
            if (m_busy) begin
                n_tests++;
                if (grant_id !== 2'(m_gid)) begin n_fail++; $display("FAIL rand_gid cyc=%0d got=%0d exp=%0d", c, grant_id, m_gid); end
            end
            if (e_wr) begin
                n_tests++;
                if (fifo_wr_data !== e_data) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, fifo_wr_data, e_data); end
            end
            n_tests++;
            if ((fifo_write && fifo_full) || (fifo_read && fifo_empty) || (fifo_write && fifo_read)) begin
                n_fail++; $display("FAIL rand_protocol cyc=%0d wr=%b full=%b rd=%b empty=%b exp no overflow/underflow/overlap", c, fifo_write, fifo_full, fifo_read, fifo_empty);
            end
            gid_now = m_gid;
            if (e_wr) pend[gid_now] = 0;
            tick();
        end
    endtask

    initial begin
        m_busy = 0; m_owed = 0; m_rdv = 0;
        m_gid = 0; m_words = 0; m_ptr = 0; m_stall = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_collision();
        test_empty_reset();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
